gen_reg_fifo_param: RTL
=======================

Name: gen_reg_fifo_param

Overview:
Parametrised register-based synchronous FIFO. It is the successor to the fixed 8-deep/267-wide register FIFO wrappers used across the DMA datapath. Adds:
- any depth (non-power-of-2 included) and any width
- selectable first-word-fall-through (FWFT) or registered-read mode
- sticky error flags, synchronous flush, high-water-mark statistics

Used for TLP header/payload staging between the PCIe core interface and the DMA engines.

Parameters:
DEPTH, 8, number of entries; legal range 2..256, need not be a power of 2.
WIDTH, 267, data word width in bits; legal range >= 1.
FWFT, 1, 1 = head word visible on dataOut while !empty; 0 = word appears one cycle after pop.
CNT_W, $clog2(DEPTH+1), derived (localparam); width of count/threshold fields.

Ports:
clockCore  in  1  single core clock, rising edge.
resetCore  in  1  asynchronous, active-low reset; deassertion synchronous to clockCore externally.
push  in  1  write request; dataIn captured when push && !full (or full && pop).
dataIn  in  WIDTH  write data.
pop  in  1  read request.
dataOut  out  WIDTH  read data (timing per FWFT).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almostFullThreshold  in  CNT_W  almostFullFlag asserted when count >= this value.
almostEmptyThreshold  in  CNT_W  almostEmptyFlag asserted when count <= this value.
almostFullFlag  out  1  see above.
almostEmptyFlag  out  1  see above.
fifoDepth  out  CNT_W  current occupancy, 0..DEPTH.
overrun  out  1  sticky: a push was dropped because the FIFO was full.
underrun  out  1  sticky: a pop was issued while the FIFO was empty.
errClear  in  1  clears overrun/underrun.
flush  in  1  synchronous empty of the FIFO.
highWater  out  CNT_W  maximum occupancy since reset or last highWaterClear.
highWaterClear  in  1  loads highWater with the current fifoDepth.

Behaviour:
- Reset (resetCore=0, async): wrPtr=rdPtr=0, count=0, overrun=underrun=0, highWater=0, dataOut=0. Storage array is not reset.
- Flags after reset: empty=1, full=0, almostEmptyFlag=1, almostFullFlag=(almostFullThreshold==0).
- Pointers: wrap from DEPTH-1 to 0 by explicit compare, not by natural overflow, so non-power-of-2 depths are correct.
- Accepted write: wrEn = push && (!full || pop). Writes storage[wrPtr] and advances wrPtr.
- Accepted read: rdEn = pop && !empty. Advances rdPtr.
- Count update: +1 on wrEn only, -1 on rdEn only, unchanged when both occur.
- Full with push && pop: both accepted, count stays DEPTH, no overrun.
- Empty with push && pop: push accepted, pop rejected (underrun set), count becomes 1. This holds in both FWFT modes.
- Flag timing: full, empty, fifoDepth and the almost flags are derived combinationally from registered count. They therefore update the cycle after the edge that changes count. Threshold inputs are applied combinationally.
- FWFT=1: dataOut = storage[rdPtr] combinationally. Valid whenever empty=0; value undefined when empty=1. A pushed word is visible the cycle after the push edge.
- FWFT=0: dataOut is a register loaded with storage[rdPtr] on the rdEn edge, so latency is 1 cycle after pop. It holds its value otherwise, including across underrun.
- overrun: set on push && full && !pop. underrun: set on pop && empty. Both are sticky and registered (visible the cycle after the event).
- errClear: clears both sticky flags. When a set and errClear occur in the same cycle, set wins.
- flush (synchronous, highest priority):
  - wrPtr=rdPtr=count=0.
  - push/pop in the same cycle are ignored and flag no errors.
  - Sticky flags, highWater and the dataOut register are unchanged.
- highWater:
  - Each cycle, highWater <= max(highWater, next_count).
  - highWaterClear loads next_count instead; it takes priority over the max update.
  - After flush, highWater keeps its value.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight push/pop is lost.

Test Plan:
1. DEPTH=8, WIDTH=267, FWFT=1: push 0x1..0x8 -> full=1 and fifoDepth=8 one cycle after the 8th push. Push 0x9 -> overrun=1, data dropped. Pop 8x -> dataOut sequence 0x1..0x8, then empty=1.
2. DEPTH=5 (non-power-of-2): 13 interleaved push/pop cycles crossing pointer wrap twice -> output order matches a reference queue exactly, and fifoDepth never exceeds 5.
3. FWFT=0: push 0xAA, pop on the next cycle -> dataOut=0xAA one cycle after pop. Pop when empty -> underrun=1, dataOut holds 0xAA. errClear -> underrun=0 the next cycle.
4. Full plus simultaneous push&pop: count stays 8, overrun stays 0, new word emerges 8 pops later. Empty plus push&pop: count=1 and underrun=1.
5. Thresholds AF=6, AE=2: fill 0→8 -> almostEmptyFlag high at counts 0..2, almostFullFlag high at counts 6..8.
6. Fill to 7, flush with push=1 -> fifoDepth=0, empty=1, highWater=7, no overrun. Then highWaterClear -> highWater=0. Assert resetCore low mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/gen_reg_fifo_param.sv
// Parametrised register-array FIFO for TLP header/payload staging: any depth/width,
// FWFT or registered read, sticky over/underrun, synchronous flush and high-water tracking.
module gen_reg_fifo_param #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 267,
  parameter  int FWFT  = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clockCore,
  input  logic             resetCore,
  input  logic             push,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pop,
  output logic [WIDTH-1:0] dataOut,
  output logic             full,
  output logic             empty,
  input  logic [CNT_W-1:0] almostFullThreshold,
  input  logic [CNT_W-1:0] almostEmptyThreshold,
  output logic             almostFullFlag,
  output logic             almostEmptyFlag,
  output logic [CNT_W-1:0] fifoDepth,
  output logic             overrun,
  output logic             underrun,
  input  logic             errClear,
  input  logic             flush,
  output logic [CNT_W-1:0] highWater,
  input  logic             highWaterClear
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, high_water_q, high_water_d;
  logic             overrun_q, overrun_d, underrun_q, underrun_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_en, rd_en;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full            = (count_q == CNT_FULL);
  assign empty           = (count_q == '0);
  assign almostFullFlag  = (count_q >= almostFullThreshold);
  assign almostEmptyFlag = (count_q <= almostEmptyThreshold);
  assign fifoDepth       = count_q;
  assign overrun         = overrun_q;
  assign underrun        = underrun_q;
  assign highWater       = high_water_q;
  assign dataOut         = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;

  always_comb begin
    wr_en        = push && (!full || pop) && !flush;
    rd_en        = pop && !empty && !flush;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overrun_d    = overrun_q;
    underrun_d   = underrun_q;
    high_water_d = high_water_q;
    dout_d       = dout_q;
    if (flush) begin
      // Flush drops occupancy only; sticky flags, high-water and read register stay frozen.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dout_d   = mem_q[rd_ptr_q];
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      if (push && full && !pop) overrun_d = 1'b1;
      else if (errClear)        overrun_d = 1'b0;
      if (pop && empty)         underrun_d = 1'b1;
      else if (errClear)        underrun_d = 1'b0;
      if (highWaterClear)             high_water_d = count_d;
      else if (count_d > high_water_q) high_water_d = count_d;
    end
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      high_water_q <= '0;
      dout_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      high_water_q <= high_water_d;
      dout_q       <= dout_d;
    end
  end

  always_ff @(posedge clockCore) begin
    if (wr_en) mem_q[wr_ptr_q] <= dataIn;
  end
endmodule
